alu_issue_station: RTL

//  Reservation station in front of the combinational ALU. Accepts dispatched ops whose operands may still be pending.

---
 rtl/alu_issue_station.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alu_issue_station.sv
// Reservation station feeding a combinational ALU: CDB wakeup, lowest-index issue, registered CDB output.
// Optional performance counters are enabled with `define ALU_ISSUE_STATION_PERF_EN.
module alu_issue_station #(
    parameter int DatapathWidth     = 32,
    parameter int AluOperationWidth = 5,
    parameter int NumEntries        = 4,
    parameter int TagWidth          = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         disp_valid_i,
    output logic                         disp_ready_o,
    input  logic [AluOperationWidth-1:0] disp_op_i,
    input  logic [TagWidth-1:0]          disp_tag_i,
    input  logic                         disp_src1_rdy_i,
    input  logic [TagWidth-1:0]          disp_src1_tag_i,
    input  logic [DatapathWidth-1:0]     disp_src1_val_i,
    input  logic                         disp_src2_rdy_i,
    input  logic [TagWidth-1:0]          disp_src2_tag_i,
    input  logic [DatapathWidth-1:0]     disp_src2_val_i,
    input  logic [DatapathWidth-1:0]     disp_imm_i,
    input  logic [DatapathWidth-1:0]     disp_pc_i,
    input  logic                         cdb_valid_i,
    input  logic [TagWidth-1:0]          cdb_tag_i,
    input  logic [DatapathWidth-1:0]     cdb_data_i,
    output logic [AluOperationWidth-1:0] alu_operation_o,
    output logic [DatapathWidth-1:0]     alu_operand1_o,
    output logic [DatapathWidth-1:0]     alu_operand2_o,
    output logic [DatapathWidth-1:0]     alu_immediate_o,
    output logic [DatapathWidth-1:0]     alu_pc_o,
    input  logic [DatapathWidth-1:0]     alu_result_i,
    input  logic                         alu_branch_taken_i,
`ifdef ALU_ISSUE_STATION_PERF_EN
    output logic [31:0]                  perf_issued_o,
    output logic [31:0]                  perf_stall_o,
`endif
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [TagWidth-1:0]          out_tag_o,
    output logic [DatapathWidth-1:0]     out_result_o,
    output logic                         out_branch_taken_o
);

    localparam int IdxW = (NumEntries > 1) ? $clog2(NumEntries) : 1;

    function automatic logic [IdxW-1:0] lowest_set(input logic [NumEntries-1:0] vec);
        lowest_set = '0;
        for (int i = NumEntries - 1; i >= 0; i--) begin
            if (vec[i]) lowest_set = IdxW'(i);
        end
    endfunction

    logic [NumEntries-1:0]        ent_vld;
    logic [NumEntries-1:0]        ent_s1_rdy;
    logic [NumEntries-1:0]        ent_s2_rdy;
    logic [AluOperationWidth-1:0] ent_op     [NumEntries];
    logic [TagWidth-1:0]          ent_tag    [NumEntries];
    logic [TagWidth-1:0]          ent_s1_tag [NumEntries];
    logic [TagWidth-1:0]          ent_s2_tag [NumEntries];
    logic [DatapathWidth-1:0]     ent_s1_val [NumEntries];
    logic [DatapathWidth-1:0]     ent_s2_val [NumEntries];
    logic [DatapathWidth-1:0]     ent_imm    [NumEntries];
    logic [DatapathWidth-1:0]     ent_pc     [NumEntries];

    logic [NumEntries-1:0] wake1;
    logic [NumEntries-1:0] wake2;
    logic [NumEntries-1:0] rdy_vec;
    logic [IdxW-1:0]       free_idx;
    logic [IdxW-1:0]       iss_idx;
    logic                  any_rdy;
    logic                  disp_fire;
    logic                  disp_s1_hit;
    logic                  disp_s2_hit;
    logic                  issue_fire;

    logic                  vld_p1;
    logic [TagWidth-1:0]   tag_p1;
    logic [DatapathWidth-1:0] res_p1;
    logic                  bt_p1;

    assign disp_ready_o = |(~ent_vld);
    assign disp_fire    = disp_valid_i && disp_ready_o;
    assign free_idx     = lowest_set(~ent_vld);
    assign rdy_vec      = ent_vld & ent_s1_rdy & ent_s2_rdy;
    assign any_rdy      = |rdy_vec;
    assign iss_idx      = lowest_set(rdy_vec);
    assign issue_fire   = any_rdy && (!vld_p1 || out_ready_i);

    // A dispatch racing a matching broadcast must not miss its wakeup.
    assign disp_s1_hit  = cdb_valid_i && !disp_src1_rdy_i && (disp_src1_tag_i == cdb_tag_i);
    assign disp_s2_hit  = cdb_valid_i && !disp_src2_rdy_i && (disp_src2_tag_i == cdb_tag_i);

    always_comb begin
        for (int i = 0; i < NumEntries; i++) begin
            wake1[i] = cdb_valid_i && ent_vld[i] && !ent_s1_rdy[i] && (ent_s1_tag[i] == cdb_tag_i);
            wake2[i] = cdb_valid_i && ent_vld[i] && !ent_s2_rdy[i] && (ent_s2_tag[i] == cdb_tag_i);
        end
    end

    // Stage p0: selected entry drives the ALU
    always_comb begin
        alu_operation_o = '0;
        alu_operand1_o  = '0;
        alu_operand2_o  = '0;
        alu_immediate_o = '0;
        alu_pc_o        = '0;
        if (any_rdy) begin
            alu_operation_o = ent_op[iss_idx];
            alu_operand1_o  = ent_s1_val[iss_idx];
            alu_operand2_o  = ent_s2_val[iss_idx];
            alu_immediate_o = ent_imm[iss_idx];
            alu_pc_o        = ent_pc[iss_idx];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ent_vld    <= '0;
            ent_s1_rdy <= '0;
            ent_s2_rdy <= '0;
        end else begin
            for (int i = 0; i < NumEntries; i++) begin
                if (wake1[i]) ent_s1_rdy[i] <= 1'b1;
                if (wake2[i]) ent_s2_rdy[i] <= 1'b1;
            end
            if (issue_fire) ent_vld[iss_idx] <= 1'b0;
            if (disp_fire) begin
                ent_vld[free_idx]    <= 1'b1;
                ent_s1_rdy[free_idx] <= disp_src1_rdy_i || disp_s1_hit;
                ent_s2_rdy[free_idx] <= disp_src2_rdy_i || disp_s2_hit;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumEntries; i++) begin
            if (wake1[i]) ent_s1_val[i] <= cdb_data_i;
            if (wake2[i]) ent_s2_val[i] <= cdb_data_i;
        end
        if (disp_fire) begin
            ent_op[free_idx]     <= disp_op_i;
            ent_tag[free_idx]    <= disp_tag_i;
            ent_s1_tag[free_idx] <= disp_src1_tag_i;
            ent_s2_tag[free_idx] <= disp_src2_tag_i;
            ent_s1_val[free_idx] <= disp_s1_hit ? cdb_data_i : disp_src1_val_i;
            ent_s2_val[free_idx] <= disp_s2_hit ? cdb_data_i : disp_src2_val_i;
            ent_imm[free_idx]    <= disp_imm_i;
            ent_pc[free_idx]     <= disp_pc_i;
        end
    end

    // Stage p1: result register toward the CDB arbiter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1 <= 1'b0;
            tag_p1 <= '0;
            res_p1 <= '0;
            bt_p1  <= 1'b0;
        end else if (issue_fire) begin
            vld_p1 <= 1'b1;
            tag_p1 <= ent_tag[iss_idx];
            res_p1 <= alu_result_i;
            bt_p1  <= alu_branch_taken_i;
        end else if (out_ready_i) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid_o        = vld_p1;
    assign out_tag_o          = tag_p1;
    assign out_result_o       = res_p1;
    assign out_branch_taken_o = bt_p1;

`ifdef ALU_ISSUE_STATION_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_issued_o <= '0;
            perf_stall_o  <= '0;
        end else begin
            if (issue_fire) perf_issued_o <= perf_issued_o + 32'd1;
            if (any_rdy && vld_p1 && !out_ready_i) perf_stall_o <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule
